// File: rtl/usb_pkg.sv
// Shared types for the USB data buffer.
// Depth, byte and occupancy widths.
package usb_pkg;
  localparam int BUF_DEPTH = 64;
  typedef logic [7:0] byte_t;
  typedef logic [6:0] occ_t;
endpackage

// File: rtl/buffer_mem.sv
// DEPTH x 8 register file with synchronous write
// and a registered read port.
module buffer_mem
  import usb_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output byte_t         rdata
);

  byte_t mem [DEPTH];
  byte_t rdata_q;
  byte_t rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its last byte when no read is granted.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/usb_buffer_arb.sv
// Arbitrates RX/host writers and TX/host readers
// onto the shared circular USB data buffer.
module usb_buffer_arb
  import usb_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_store_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_tx_packet_data,
  input  logic       get_rx_data,
  input  logic       flush,
  output logic [7:0] rd_data,
  output logic       tx_rd_valid,
  output logic       host_rd_valid,
  output logic [6:0] buffer_occupancy,
  output logic       wr_denied,
  output logic       rd_denied
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  occ_t          occ_q, occ_d;
  logic          tx_vld_q, tx_vld_d;
  logic          host_vld_q, host_vld_d;
  logic          wr_den_q, wr_den_d;
  logic          rd_den_q, rd_den_d;

  logic  wr_req, rd_req;
  logic  wr_ok, rd_ok;
  logic  full, empty;
  byte_t wr_byte;

  assign full    = (occ_q == occ_t'(DEPTH));
  assign empty   = (occ_q == '0);
  assign wr_req  = rx_store_packet_data | store_tx_data;
  assign rd_req  = get_tx_packet_data | get_rx_data;
  assign wr_byte = rx_store_packet_data ? rx_packet_data : tx_data;
  assign wr_ok   = wr_req & ~full & ~flush;
  assign rd_ok   = rd_req & ~empty & ~flush;

  // Flush suppresses every grant and every denied pulse.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q + occ_t'(wr_ok) - occ_t'(rd_ok);
    tx_vld_d   = rd_ok & get_tx_packet_data;
    host_vld_d = rd_ok & ~get_tx_packet_data;
    wr_den_d   = ~flush & ((rx_store_packet_data & store_tx_data)
                           | (wr_req & full));
    rd_den_d   = ~flush & ((get_tx_packet_data & get_rx_data)
                           | (rd_req & empty));
    if (wr_ok) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      tx_vld_q   <= 1'b0;
      host_vld_q <= 1'b0;
      wr_den_q   <= 1'b0;
      rd_den_q   <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      tx_vld_q   <= tx_vld_d;
      host_vld_q <= host_vld_d;
      wr_den_q   <= wr_den_d;
      rd_den_q   <= rd_den_d;
    end
  end

  buffer_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (wr_byte),
    .re    (rd_ok),
    .raddr (rptr_q),
    .rdata (rd_data)
  );

  assign tx_rd_valid      = tx_vld_q;
  assign host_rd_valid    = host_vld_q;
  assign buffer_occupancy = occ_q;
  assign wr_denied        = wr_den_q;
  assign rd_denied        = rd_den_q;

endmodule

// File: tb/tb_usb_buffer_arb.sv
// Directed self-checking bench for usb_buffer_arb.
// Inputs change 1ns after the rising edge; outputs sampled there.
module tb_usb_buffer_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_we, host_we, tx_re, host_re, fl;
  logic [7:0] rx_d, host_d;
  logic [7:0] rd_data;
  logic       tx_v, host_v, wr_den, rd_den;
  logic [6:0] occ;

  int errs = 0;
  int checks = 0;
  logic [7:0] q[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  usb_buffer_arb dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_store_packet_data (rx_we),
    .rx_packet_data       (rx_d),
    .store_tx_data        (host_we),
    .tx_data              (host_d),
    .get_tx_packet_data   (tx_re),
    .get_rx_data          (host_re),
    .flush                (fl),
    .rd_data              (rd_data),
    .tx_rd_valid          (tx_v),
    .host_rd_valid        (host_v),
    .buffer_occupancy     (occ),
    .wr_denied            (wr_den),
    .rd_denied            (rd_den)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    rx_we = 0; host_we = 0; tx_re = 0; host_re = 0; fl = 0;
    rx_d = 8'h00; host_d = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic rx_wr(input logic [7:0] b);
    rx_we = 1; rx_d = b;
    tick();
  endtask

  task automatic tx_rd();
    tx_re = 1;
    tick();
  endtask

  initial begin
    clr();
    rst = 1;
    #12;
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_tx_v", int'(tx_v), 0);
    chk("rst_host_v", int'(host_v), 0);
    chk("rst_occ", int'(occ), 0);
    chk("rst_wr_den", int'(wr_den), 0);
    chk("rst_rd_den", int'(rd_den), 0);
    rst = 0;
    @(posedge clk); #1;

    // basic write/read
    rx_wr(8'hC3); chk("occ1", int'(occ), 1);
    rx_wr(8'hFF); chk("occ2", int'(occ), 2);
    rx_wr(8'hAA); chk("occ3", int'(occ), 3);
    tx_rd();
    chk("rd0", int'(rd_data), 'hC3); chk("rd0_v", int'(tx_v), 1);
    chk("rd0_hv", int'(host_v), 0); chk("rd0_occ", int'(occ), 2);
    tx_rd();
    chk("rd1", int'(rd_data), 'hFF); chk("rd1_v", int'(tx_v), 1);
    chk("rd1_occ", int'(occ), 1);
    tx_rd();
    chk("rd2", int'(rd_data), 'hAA); chk("rd2_v", int'(tx_v), 1);
    chk("rd2_occ", int'(occ), 0);
    @(posedge clk); #1;
    chk("rd_v_pulse", int'(tx_v), 0);

    // write and read arbitration
    rx_we = 1; rx_d = 8'h11; host_we = 1; host_d = 8'h22;
    tick();
    chk("warb_den", int'(wr_den), 1); chk("warb_occ", int'(occ), 1);
    host_we = 1; host_d = 8'h33;
    tick();
    chk("hwr_den", int'(wr_den), 0); chk("hwr_occ", int'(occ), 2);
    tx_re = 1; host_re = 1;
    tick();
    chk("rarb_data", int'(rd_data), 'h11);
    chk("rarb_txv", int'(tx_v), 1); chk("rarb_hv", int'(host_v), 0);
    chk("rarb_den", int'(rd_den), 1); chk("rarb_occ", int'(occ), 1);
    host_re = 1;
    tick();
    chk("hrd_data", int'(rd_data), 'h33);
    chk("hrd_hv", int'(host_v), 1); chk("hrd_txv", int'(tx_v), 0);
    chk("hrd_den", int'(rd_den), 0); chk("hrd_occ", int'(occ), 0);

    // empty
    tx_rd();
    chk("emp_data", int'(rd_data), 'h33); chk("emp_v", int'(tx_v), 0);
    chk("emp_den", int'(rd_den), 1); chk("emp_occ", int'(occ), 0);
    rx_we = 1; rx_d = 8'h44; tx_re = 1;
    tick();
    chk("empwr_occ", int'(occ), 1); chk("empwr_v", int'(tx_v), 0);
    chk("empwr_den", int'(rd_den), 1); chk("empwr_data", int'(rd_data), 'h33);
    chk("empwr_wden", int'(wr_den), 0);
    fl = 1;
    tick();
    chk("fl0_occ", int'(occ), 0);

    // fill to full
    for (int i = 0; i < 64; i++) rx_wr(8'(i));
    chk("full_occ", int'(occ), 64);
    chk("full_wden0", int'(wr_den), 0);
    rx_wr(8'hEE);
    chk("ovf_den", int'(wr_den), 1); chk("ovf_occ", int'(occ), 64);
    rx_we = 1; rx_d = 8'hEE; tx_re = 1;
    tick();
    chk("fullrw_data", int'(rd_data), 0); chk("fullrw_v", int'(tx_v), 1);
    chk("fullrw_wden", int'(wr_den), 1); chk("fullrw_occ", int'(occ), 63);
    for (int i = 1; i < 64; i++) begin
      tx_rd();
      chk("drain", int'(rd_data), i);
    end
    chk("drain_occ", int'(occ), 0);

    // wrap: 70 writes, 70 reads interleaved
    q.delete();
    for (int i = 0; i < 4; i++) begin
      rx_wr(8'(i * 7 + 1)); q.push_back(8'(i * 7 + 1));
    end
    for (int i = 4; i < 70; i++) begin
      rx_we = 1; rx_d = 8'(i * 7 + 1); tx_re = 1;
      q.push_back(8'(i * 7 + 1));
      exp_b = q.pop_front();
      tick();
      chk("wrap_data", int'(rd_data), int'(exp_b));
      chk("wrap_occ", int'(occ), 4);
    end
    for (int i = 0; i < 4; i++) begin
      exp_b = q.pop_front();
      tx_rd();
      chk("wrap_tail", int'(rd_data), int'(exp_b));
    end
    chk("wrap_end_occ", int'(occ), 0);

    // flush with concurrent requests
    for (int i = 0; i < 5; i++) rx_wr(8'(8'h50 + i));
    chk("pre_fl_occ", int'(occ), 5);
    fl = 1; rx_we = 1; rx_d = 8'h99; host_we = 1; host_d = 8'h98;
    tx_re = 1; host_re = 1;
    tick();
    chk("fl_occ", int'(occ), 0); chk("fl_wden", int'(wr_den), 0);
    chk("fl_rden", int'(rd_den), 0); chk("fl_txv", int'(tx_v), 0);
    chk("fl_hv", int'(host_v), 0);
    tx_rd();
    chk("postfl_den", int'(rd_den), 1); chk("postfl_v", int'(tx_v), 0);

    // async reset mid-stream
    rx_wr(8'hA1);
    rx_wr(8'hA2);
    tx_rd();
    chk("prerst_data", int'(rd_data), 'hA1); chk("prerst_v", int'(tx_v), 1);
    #2 rst = 1;
    #1;
    chk("arst_data", int'(rd_data), 0); chk("arst_v", int'(tx_v), 0);
    chk("arst_occ", int'(occ), 0); chk("arst_hv", int'(host_v), 0);
    chk("arst_wden", int'(wr_den), 0); chk("arst_rden", int'(rd_den), 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    rx_wr(8'h5A);
    tx_rd();
    chk("postrst_data", int'(rd_data), 'h5A);
    chk("postrst_occ", int'(occ), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
